// File: rtl/overture_io_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : overture_io_pkg                                              |
// | Description : Shared constants and types for the OVERTURE byte-stream port |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
package overture_io_pkg;

    localparam int OVERTURE_DATA_W = 8;

    localparam int FLAG_UNDERFLOW = 0;
    localparam int FLAG_OVERFLOW  = 1;

    typedef logic [OVERTURE_DATA_W-1:0] data_t;

endpackage
`default_nettype wire

// File: rtl/overture_io_fifo.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : overture_io_fifo                                             |
// | Description : Show-ahead synchronous FIFO, level-based full/empty, no      |
// |               fall-through; a push into a full FIFO lands if it pops too.  |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module overture_io_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 16
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       push,
    input  logic [WIDTH-1:0]           push_data,
    input  logic                       pop,
    output logic [WIDTH-1:0]           head,
    output logic                       full,
    output logic                       empty,
    output logic [$clog2(DEPTH+1)-1:0] level
);

    localparam int c_PTR_W = $clog2(DEPTH);
    localparam int c_LVL_W = $clog2(DEPTH + 1);

    logic [WIDTH-1:0]   r_mem [DEPTH];
    logic [c_PTR_W-1:0] r_wr_ptr;
    logic [c_PTR_W-1:0] r_rd_ptr;
    logic [c_LVL_W-1:0] r_level;
    logic               w_pop_ok;
    logic               w_push_ok;

    assign full      = (r_level == c_LVL_W'(DEPTH));
    assign empty     = (r_level == '0);
    assign level     = r_level;
    assign w_pop_ok  = pop & ~empty;
    assign w_push_ok = push & (~full | w_pop_ok);
    // Forced to zero when empty so the head reads 0 straight after reset.
    assign head      = empty ? '0 : r_mem[r_rd_ptr];

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_level  <= '0;
        end else begin
            if (w_push_ok) r_wr_ptr <= r_wr_ptr + c_PTR_W'(1);
            if (w_pop_ok)  r_rd_ptr <= r_rd_ptr + c_PTR_W'(1);
            case ({w_push_ok, w_pop_ok})
                2'b10:   r_level <= r_level + c_LVL_W'(1);
                2'b01:   r_level <= r_level - c_LVL_W'(1);
                default: r_level <= r_level;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (w_push_ok) r_mem[r_wr_ptr] <= push_data;
    end

endmodule
`default_nettype wire

// File: rtl/overture_io_port.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : overture_io_port                                             |
// | Description : Buffered byte-stream I/O between the OVERTURE core handshake |
// |               and external valid/ready streams. Define                     |
// |               OVERTURE_IO_LOOPBACK_EN to add the output->input loopback.   |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module overture_io_port
    import overture_io_pkg::*;
#(
    parameter int              DATA_W      = OVERTURE_DATA_W,
    parameter int              IN_DEPTH    = 16,
    parameter int              OUT_DEPTH   = 16,
    parameter logic [DATA_W-1:0] EMPTY_VALUE = '0
) (
    input  logic                           clk,
    input  logic                           rst,
`ifdef OVERTURE_IO_LOOPBACK_EN
    input  logic                           loopback,
`endif
    input  logic                           arch_input_enable,
    output logic [DATA_W-1:0]              arch_input_value,
    input  logic                           arch_output_enable,
    input  logic [DATA_W-1:0]              arch_output_value,
    input  logic                           ext_in_valid,
    input  logic [DATA_W-1:0]              ext_in_data,
    output logic                           ext_in_ready,
    output logic                           ext_out_valid,
    output logic [DATA_W-1:0]              ext_out_data,
    input  logic                           ext_out_ready,
    output logic [$clog2(IN_DEPTH+1)-1:0]  in_level,
    output logic [$clog2(OUT_DEPTH+1)-1:0] out_level,
    output logic                           in_underflow,
    output logic                           out_overflow,
    input  logic                           clr_flags
);

    logic              w_lb;
    logic              w_in_full;
    logic              w_in_empty;
    logic [DATA_W-1:0] w_in_head;
    logic              w_in_push;
    logic [DATA_W-1:0] w_in_push_data;
    logic              w_in_pop;
    logic              w_out_full;
    logic              w_out_empty;
    logic [DATA_W-1:0] w_out_head;
    logic              w_out_pop;
    logic              w_lb_xfer;
    logic              w_read_fire;
    logic [1:0]        w_flag_set;
    logic              r_enable_q;
    logic [DATA_W-1:0] r_arch_value;
    logic [1:0]        r_flags;

`ifdef OVERTURE_IO_LOOPBACK_EN
    assign w_lb = loopback;
`else
    assign w_lb = 1'b0;
`endif

    // Ready depends on registered fullness only, never on ext_in_valid.
    assign ext_in_ready   = ~w_in_full & ~w_lb;
    assign ext_out_valid  = ~w_out_empty & ~w_lb;
    assign ext_out_data   = w_out_head;

    assign w_lb_xfer      = w_lb & ~w_out_empty & ~w_in_full;
    assign w_in_push      = w_lb ? w_lb_xfer : (ext_in_valid & ext_in_ready);
    assign w_in_push_data = w_lb ? w_out_head : ext_in_data;
    assign w_out_pop      = w_lb ? w_lb_xfer : (ext_out_valid & ext_out_ready);

    assign w_read_fire    = arch_input_enable & ~r_enable_q;
    assign w_in_pop       = w_read_fire & ~w_in_empty;

    always_comb begin
        w_flag_set                 = '0;
        w_flag_set[FLAG_UNDERFLOW] = w_read_fire & w_in_empty;
        w_flag_set[FLAG_OVERFLOW]  = arch_output_enable & w_out_full & ~w_out_pop;
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_enable_q   <= 1'b0;
            r_arch_value <= '0;
            r_flags      <= '0;
        end else begin
            r_enable_q <= arch_input_enable;
            if (!arch_input_enable) begin
                r_arch_value <= '0;
            end else if (w_read_fire) begin
                r_arch_value <= w_in_empty ? EMPTY_VALUE : w_in_head;
            end
            // A set in the same cycle as clear wins.
            r_flags <= w_flag_set | (r_flags & {2{~clr_flags}});
        end
    end

    assign arch_input_value = r_arch_value;
    assign in_underflow     = r_flags[FLAG_UNDERFLOW];
    assign out_overflow     = r_flags[FLAG_OVERFLOW];

    overture_io_fifo #(
        .WIDTH (DATA_W),
        .DEPTH (IN_DEPTH)
    ) u_in_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (w_in_push),
        .push_data (w_in_push_data),
        .pop       (w_in_pop),
        .head      (w_in_head),
        .full      (w_in_full),
        .empty     (w_in_empty),
        .level     (in_level)
    );

    overture_io_fifo #(
        .WIDTH (DATA_W),
        .DEPTH (OUT_DEPTH)
    ) u_out_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (arch_output_enable),
        .push_data (arch_output_value),
        .pop       (w_out_pop),
        .head      (w_out_head),
        .full      (w_out_full),
        .empty     (w_out_empty),
        .level     (out_level)
    );

endmodule
`default_nettype wire

// File: tb/tb_overture_io_port.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : tb_overture_io_port                                          |
// | Description : Self-checking bench for overture_io_port against a queue     |
// |               based reference model; directed steps then random traffic.   |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module tb_overture_io_port;
    import overture_io_pkg::*;

    localparam int    IN_DEPTH    = 16;
    localparam int    OUT_DEPTH   = 16;
    localparam data_t EMPTY_VALUE = 8'h00;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
`ifdef OVERTURE_IO_LOOPBACK_EN
    logic        loopback = 1'b0;
`endif
    logic        arch_input_enable  = 1'b0;
    data_t       arch_input_value;
    logic        arch_output_enable = 1'b0;
    data_t       arch_output_value  = '0;
    logic        ext_in_valid       = 1'b0;
    data_t       ext_in_data        = '0;
    logic        ext_in_ready;
    logic        ext_out_valid;
    data_t       ext_out_data;
    logic        ext_out_ready      = 1'b0;
    logic [4:0]  in_level;
    logic [4:0]  out_level;
    logic        in_underflow;
    logic        out_overflow;
    logic        clr_flags          = 1'b0;

    overture_io_port #(
        .DATA_W      (OVERTURE_DATA_W),
        .IN_DEPTH    (IN_DEPTH),
        .OUT_DEPTH   (OUT_DEPTH),
        .EMPTY_VALUE (EMPTY_VALUE)
    ) dut (
        .clk                (clk),
        .rst                (rst),
`ifdef OVERTURE_IO_LOOPBACK_EN
        .loopback           (loopback),
`endif
        .arch_input_enable  (arch_input_enable),
        .arch_input_value   (arch_input_value),
        .arch_output_enable (arch_output_enable),
        .arch_output_value  (arch_output_value),
        .ext_in_valid       (ext_in_valid),
        .ext_in_data        (ext_in_data),
        .ext_in_ready       (ext_in_ready),
        .ext_out_valid      (ext_out_valid),
        .ext_out_data       (ext_out_data),
        .ext_out_ready      (ext_out_ready),
        .in_level           (in_level),
        .out_level          (out_level),
        .in_underflow       (in_underflow),
        .out_overflow       (out_overflow),
        .clr_flags          (clr_flags)
    );

    always #5 clk = ~clk;

    int    n_pass  = 0;
    int    n_total = 0;
    data_t in_q[$];
    data_t out_q[$];
    data_t m_arch  = '0;
    logic  m_en_q  = 1'b0;
    logic  m_uf    = 1'b0;
    logic  m_ov    = 1'b0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    endtask

    function automatic logic lb_now();
        logic lb;
        lb = 1'b0;
`ifdef OVERTURE_IO_LOOPBACK_EN
        lb = loopback;
`endif
        return lb;
    endfunction

    // Reference behaviour for one clock edge, using the inputs currently driven.
    task automatic model_edge();
        logic  lb, in_full, out_full, lbx, out_pop, uf_set, ov_set;
        data_t lbw;
        if (!rst) begin
            in_q.delete();
            out_q.delete();
            m_arch = '0;
            m_en_q = 1'b0;
            m_uf   = 1'b0;
            m_ov   = 1'b0;
            return;
        end
        lb       = lb_now();
        in_full  = (in_q.size() >= IN_DEPTH);
        out_full = (out_q.size() >= OUT_DEPTH);
        lbx      = lb && (out_q.size() > 0) && !in_full;
        lbw      = lbx ? out_q[0] : '0;
        uf_set   = 1'b0;
        ov_set   = 1'b0;
        if (!arch_input_enable) begin
            m_arch = '0;
        end else if (!m_en_q) begin
            if (in_q.size() > 0) m_arch = in_q.pop_front();
            else begin
                m_arch = EMPTY_VALUE;
                uf_set = 1'b1;
            end
        end
        out_pop = lb ? lbx : ((out_q.size() > 0) && ext_out_ready);
        if (out_pop) void'(out_q.pop_front());
        if (arch_output_enable) begin
            if (!out_full || out_pop) out_q.push_back(arch_output_value);
            else ov_set = 1'b1;
        end
        if (lb ? lbx : (ext_in_valid && !in_full)) in_q.push_back(lb ? lbw : ext_in_data);
        m_uf   = uf_set | (m_uf & !clr_flags);
        m_ov   = ov_set | (m_ov & !clr_flags);
        m_en_q = arch_input_enable;
    endtask

    task automatic check_all();
        logic lb;
        lb = lb_now();
        chk("in_level", 32'(in_level), in_q.size());
        chk("out_level", 32'(out_level), out_q.size());
        chk("ext_in_ready", 32'(ext_in_ready), 32'(!lb && in_q.size() < IN_DEPTH));
        chk("ext_out_valid", 32'(ext_out_valid), 32'(!lb && out_q.size() > 0));
        if (!lb && out_q.size() > 0) chk("ext_out_data", 32'(ext_out_data), 32'(out_q[0]));
        chk("arch_input_value", 32'(arch_input_value), 32'(m_arch));
        chk("in_underflow", 32'(in_underflow), 32'(m_uf));
        chk("out_overflow", 32'(out_overflow), 32'(m_ov));
    endtask

    task automatic step();
        model_edge();
        @(posedge clk);
        #1;
        check_all();
    endtask

    initial begin
        // Reset with data queued
        step(); step();
        rst = 1'b1;
        ext_in_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            ext_in_data = data_t'($urandom);
            step();
        end
        ext_in_valid = 1'b0;
        rst = 1'b0;
        step();
        rst = 1'b1;
        chk("rst_in_level", 32'(in_level), 0);
        chk("rst_ext_in_ready", 32'(ext_in_ready), 1);
        chk("rst_arch_value", 32'(arch_input_value), 0);
        chk("rst_ext_out_data", 32'(ext_out_data), 0);
        chk("rst_flags", {30'd0, in_underflow, out_overflow}, 0);

        // Stream in three words, then rising-level core reads
        ext_in_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            ext_in_data = data_t'(8'h41 + i);
            step();
        end
        ext_in_valid = 1'b0;
        arch_input_enable = 1'b1;
        for (int i = 0; i < 4; i++) begin
            step();
            chk("read_hold_41", 32'(arch_input_value), 32'h41);
        end
        arch_input_enable = 1'b0;
        step();
        chk("read_low_zero", 32'(arch_input_value), 0);
        arch_input_enable = 1'b1;
        step();
        chk("read_second_42", 32'(arch_input_value), 32'h42);
        chk("read_level_1", 32'(in_level), 1);

        // Drain the last word, then read an empty FIFO
        arch_input_enable = 1'b0; step();
        arch_input_enable = 1'b1; step();
        arch_input_enable = 1'b0; step();
        arch_input_enable = 1'b1; step();
        chk("underflow_value", 32'(arch_input_value), 32'(EMPTY_VALUE));
        chk("underflow_set", 32'(in_underflow), 1);
        step();
        arch_input_enable = 1'b0; step();
        arch_input_enable = 1'b1; clr_flags = 1'b1; step();
        chk("set_beats_clr", 32'(in_underflow), 1);
        arch_input_enable = 1'b0; step();
        chk("clr_underflow", 32'(in_underflow), 0);
        clr_flags = 1'b0;

        // Overfill the output FIFO with no consumer
        arch_output_enable = 1'b1;
        for (int i = 0; i < 17; i++) begin
            arch_output_value = data_t'(i);
            step();
        end
        chk("ovf_level", 32'(out_level), 16);
        chk("ovf_flag", 32'(out_overflow), 1);
        arch_output_enable = 1'b0;
        clr_flags = 1'b1; step(); clr_flags = 1'b0;

        // Full FIFO: write and pop at the same edge
        arch_output_enable = 1'b1;
        arch_output_value  = 8'hAA;
        ext_out_ready      = 1'b1;
        step();
        chk("full_swap_level", 32'(out_level), 16);
        chk("full_swap_no_ovf", 32'(out_overflow), 0);
        arch_output_enable = 1'b0;
        for (int i = 0; i < 16; i++) step();
        chk("drained_level", 32'(out_level), 0);

        // Continuous write/drain across pointer wrap
        arch_output_enable = 1'b1;
        for (int i = 0; i < 40; i++) begin
            arch_output_value = data_t'($urandom);
            ext_out_ready = ($urandom_range(0, 3) != 0);
            step();
        end
        arch_output_enable = 1'b0;
        ext_out_ready = 1'b1;
        for (int i = 0; i < 20; i++) step();

        // Random traffic
        for (int i = 0; i < 600; i++) begin
            rst                = ($urandom_range(0, 199) != 0);
            ext_in_valid       = $urandom_range(0, 1) == 1;
            ext_in_data        = data_t'($urandom);
            arch_output_enable = ($urandom_range(0, 4) < 2);
            arch_output_value  = data_t'($urandom);
            ext_out_ready      = $urandom_range(0, 1) == 1;
            clr_flags          = ($urandom_range(0, 15) == 0);
            if ($urandom_range(0, 2) == 0) arch_input_enable = ~arch_input_enable;
`ifdef OVERTURE_IO_LOOPBACK_EN
            if ($urandom_range(0, 9) == 0) loopback = ~loopback;
`endif
            step();
        end
        rst = 1'b1;
        clr_flags = 1'b0;
        ext_in_valid = 1'b0;
        arch_output_enable = 1'b0;
        arch_input_enable = 1'b0;

`ifdef OVERTURE_IO_LOOPBACK_EN
        // Loopback: a core write returns on the core read side
        rst = 1'b0; step(); rst = 1'b1;
        loopback = 1'b1;
        ext_out_ready = 1'b1;
        arch_output_enable = 1'b1;
        arch_output_value  = 8'h55;
        step();
        arch_output_enable = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step();
            chk("lb_out_valid", 32'(ext_out_valid), 0);
        end
        arch_input_enable = 1'b1;
        step();
        chk("lb_read_55", 32'(arch_input_value), 32'h55);
        arch_input_enable = 1'b0;
        loopback = 1'b0;
        step();
`endif

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/overture_io_port.md
Name: overture_io_port

Overview:
- Parametrised byte-stream I/O port between the OVERTURE core's arch_input/arch_output handshake and external streaming producers and consumers.
- Input side: an elastic FIFO that the core drains one entry per arch_input_enable request.
- Output side: a FIFO filled by arch_output_enable and drained through a valid/ready stream.
- Adds buffering, level reporting and sticky error flags that the bare core handshake lacks.

Parameters:
- DATA_W, 8: width of every data word.
- IN_DEPTH, 16: input FIFO entries; power of two, minimum 2.
- OUT_DEPTH, 16: output FIFO entries; power of two, minimum 2.
- EMPTY_VALUE, 0: value returned to the core on a read from an empty input FIFO.

Ports:
- clk  in  1  single clock; all logic on rising edge.
- rst  in  1  synchronous, active-low reset.
- arch_input_enable  in  1  core read request (level).
- arch_input_value  out  DATA_W  word returned to core.
- arch_output_enable  in  1  core write strobe; one word per high cycle.
- arch_output_value  in  DATA_W  word written by core.
- ext_in_valid  in  1  external producer has data.
- ext_in_data  in  DATA_W  external producer data.
- ext_in_ready  out  1  input FIFO can accept.
- ext_out_valid  out  1  output FIFO non-empty.
- ext_out_data  out  DATA_W  output FIFO head.
- ext_out_ready  in  1  external consumer accepts.
- in_level  out  $clog2(IN_DEPTH+1)  input FIFO occupancy.
- out_level  out  $clog2(OUT_DEPTH+1)  output FIFO occupancy.
- in_underflow  out  1  sticky: core read an empty input FIFO.
- out_overflow  out  1  sticky: core write dropped because the output FIFO was full.
- clr_flags  in  1  clears both sticky flags.

Behaviour:
- Reset: at a clk edge with rst=0, both FIFOs are flushed mid-operation included, and in-flight data is lost. All outputs go to 0 except ext_in_ready, which goes to 1. The internal enable_q register is cleared.
- Input push: at an edge with ext_in_valid & ext_in_ready, the word is written. ext_in_ready = !in_full, derived from registered state only and never from ext_in_valid.
- Core read: a read fires at an edge where arch_input_enable=1 and enable_q=0 (rising-level detect).
  - If the FIFO is non-empty, the head is popped into the arch_input_value register.
  - If the FIFO is empty, arch_input_value is loaded with EMPTY_VALUE and in_underflow is set.
  - arch_input_value holds while enable stays high and returns to 0 at the first edge where enable is sampled low.
  - A continuous high level gives exactly one pop.
- Latency: a word pushed at edge N is poppable at edge N+1 or later. There is no fall-through, so a push and a read on an empty FIFO at the same edge is an underflow.
- Core write: at every edge with arch_output_enable=1, arch_output_value is pushed.
  - If the output FIFO is full and no external pop occurs at that edge, the word is dropped and out_overflow is set.
  - If full and ext_out_ready & ext_out_valid at the same edge, the push succeeds and the level is unchanged.
- Output drain: show-ahead. ext_out_data equals the head whenever ext_out_valid=1. A word is popped at an edge with ext_out_valid & ext_out_ready. ext_out_valid and ext_out_data are stable while ready=0.
- Levels: updated every edge as level + push - pop, and never exceed DEPTH. Pointers are log2(DEPTH) bits and wrap naturally. Full and empty are distinguished by level.
- Flags: a set at the same edge as clr_flags takes priority, so the flag stays 1.

Optional Feature:
- Macro: OVERTURE_IO_LOOPBACK_EN.
- Defined:
  - Extra port loopback (in, 1).
  - When loopback=1:
    - The output FIFO head feeds the input FIFO push at edges where the output FIFO is non-empty and the input FIFO is not full, one word per edge.
    - ext_out_valid is forced 0 and ext_in_ready is forced 0.
  - Switching loopback takes effect at the next edge. Words already in the FIFOs are preserved.
- Undefined: no loopback port, and the external paths are always active.

Decomposition:
- Package overture_io_pkg holds: DATA_W default constant; flag-index localparams (FLAG_UNDERFLOW=0, FLAG_OVERFLOW=1); a typedef for the data word.
- One sub-module, overture_io_fifo: synchronous FIFO with parameters WIDTH and DEPTH.
  - Ports: push, push_data, pop, head, full, empty, level.
  - Instantiated twice. The top level holds only the read-detect, flag and loopback logic.

Test Plan:
- Reset with data queued: push 3 words, assert rst=0 for 1 cycle → in_level=0, ext_in_ready=1, arch_input_value=0, both flags 0.
- Stream in 0x41,0x42,0x43; core raises enable for 4 cycles, lowers, raises again → arch_input_value=0x41 held for 4 cycles, then 0, then 0x42; in_level goes 3→2→1.
- Core read with input FIFO empty, EMPTY_VALUE=0 → arch_input_value=0x00, in_underflow=1 until clr_flags; a simultaneous set and clr leaves it at 1.
- Core writes 17 words with OUT_DEPTH=16 and ext_out_ready=0 → out_level=16, out_overflow=1, word 17 lost. Raising ready drains words 0..15 in order, one per cycle.
- Full output FIFO, core write and external pop at the same edge → out_level stays 16, no overflow, new word appears last.
- With OUT_DEPTH=4, push 10 words while draining continuously → in-order data across pointer wrap; with OVERTURE_IO_LOOPBACK_EN, loopback=1 and core writes 0x55 → core later reads 0x55, ext_out_valid stays 0.
